// File: rtl/prng_pkg.sv
// rtl/prng_pkg.sv - shared constants and state type for the PRNG range/FIFO block
package prng_pkg;

    localparam int RND_W      = 32;
    localparam int REM_CYCLES = 32;

    typedef enum logic {RUN, CALC} range_state_t;

endpackage

// File: rtl/prng_rem_calc.sv
// rtl/prng_rem_calc.sv - 32-cycle restoring remainder engine for the rejection threshold
module prng_rem_calc
    import prng_pkg::*;
#(
    parameter int WOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RND_W-1:0] dividend,
    input  logic [WOUT:0]    divisor,
    output logic             busy,
    output logic             done,
    output logic [WOUT-1:0]  rem
);

    localparam int CW = $clog2(REM_CYCLES);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [RND_W-1:0] r_dividend;
    logic [WOUT-1:0]  r_rem;
    logic [WOUT:0]    r_divisor;

    logic [WOUT:0]    w_shift;
    logic [WOUT-1:0]  w_rem_next;

    // One restoring step: bring in the next dividend bit, subtract the divisor if it fits.
    // The partial remainder stays below the divisor, so WOUT bits hold it between steps.
    always_comb begin
        w_shift    = {r_rem, r_dividend[RND_W-1]};
        w_rem_next = (w_shift >= r_divisor) ? WOUT'(w_shift - r_divisor) : WOUT'(w_shift);
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == CW'(REM_CYCLES - 1));
    assign rem  = w_rem_next;

    // Iteration state: a start (even mid-run) reloads operands and restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
        end else if (start) begin
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_dividend <= dividend;
            r_rem      <= '0;
            r_divisor  <= divisor;
        end else if (r_busy) begin
            r_rem      <= w_rem_next;
            r_dividend <= {r_dividend[RND_W-2:0], 1'b0};
            r_cnt      <= r_cnt + CW'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prng_range_fifo.sv
// rtl/prng_range_fifo.sv - unbiased [0,N) sampler with FIFO output; PRNG_RANGE_STATS_EN enables counters
module prng_range_fifo
    import prng_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WOUT  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RND_W-1:0] rnd_in,
    input  logic             rnd_valid,
    input  logic             cfg_load,
    input  logic [WOUT-1:0]  cfg_n,
    output logic             busy,
    output logic [WOUT-1:0]  m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [CNT_W-1:0] reject_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = RND_W + WOUT;

    range_state_t     r_state, w_state_next;
    logic [WOUT-1:0]  r_n, r_t;
    logic [WOUT:0]    w_n_eff, w_cfg_eff;
    logic [RND_W-1:0] w_dividend;
    logic             w_eng_busy, w_eng_done;
    logic [WOUT-1:0]  w_eng_rem;

    logic             r_s1_v, r_s2_v;
    logic [PW-1:0]    r_s1_m;
    logic [WOUT-1:0]  r_s2_d;
    logic             w_take, w_lt;
    logic [PW-1:0]    w_prod;

    logic [WOUT-1:0]  r_mem [DEPTH];
    logic [AW:0]      r_wptr, r_rptr;
    logic             w_empty, w_full, w_pop, w_push;

    // N = 0 stands for 2^WOUT, so the effective range needs one extra bit.
    assign w_n_eff    = (r_n == '0)   ? {1'b1, {WOUT{1'b0}}} : {1'b0, r_n};
    assign w_cfg_eff  = (cfg_n == '0) ? {1'b1, {WOUT{1'b0}}} : {1'b0, cfg_n};
    assign w_dividend = ~{{(RND_W-WOUT-1){1'b0}}, w_cfg_eff} + RND_W'(1);

    prng_rem_calc #(.WOUT(WOUT)) u_rem_calc (
        .clk      (clk),
        .rst      (rst),
        .start    (cfg_load),
        .dividend (w_dividend),
        .divisor  (w_cfg_eff),
        .busy     (w_eng_busy),
        .done     (w_eng_done),
        .rem      (w_eng_rem)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_next;
    end

    // Next state: any load (re)enters CALC; CALC ends on the engine's final step.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (cfg_load) w_state_next = CALC;
            CALC:    if (cfg_load) w_state_next = CALC;
                     else if (w_eng_done) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    assign busy = (r_state == CALC);

    // Range and threshold registers; T is captured on the engine's last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n <= '0;
            r_t <= '0;
        end else if (cfg_load) begin
            r_n <= cfg_n;
        end else if ((r_state == CALC) && w_eng_done) begin
            r_t <= w_eng_rem;
        end
    end

    assign w_take = rnd_valid && (r_state == RUN) && !w_eng_busy && !cfg_load;
    assign w_prod = {{WOUT{1'b0}}, rnd_in} * {{(PW-WOUT-1){1'b0}}, w_n_eff};
    assign w_lt   = r_s1_m[RND_W-1:0] < {{(RND_W-WOUT){1'b0}}, r_t};

    // Two-stage datapath: S1 holds the product, S2 holds an accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s1_m <= '0;
            r_s2_v <= 1'b0;
            r_s2_d <= '0;
        end else begin
            r_s1_v <= w_take;
            if (w_take) r_s1_m <= w_prod;
            r_s2_v <= r_s1_v && !w_lt && !cfg_load;
            if (r_s1_v) r_s2_d <= r_s1_m[PW-1:RND_W];
        end
    end

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop    = !w_empty && m_tready;
    assign w_push   = r_s2_v && !cfg_load && (!w_full || w_pop);
    assign m_tvalid = !w_empty;
    assign m_tdata  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // FIFO pointers; a load empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (cfg_load) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= r_s2_d;
    end

`ifdef PRNG_RANGE_STATS_EN
    logic             w_reject, w_drop;
    logic [CNT_W-1:0] r_reject_cnt, r_drop_cnt;

    assign w_reject = r_s1_v && w_lt && !cfg_load;
    assign w_drop   = r_s2_v && !cfg_load && w_full && !w_pop;

    // Saturating statistics, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reject_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_reject && (r_reject_cnt != '1)) r_reject_cnt <= r_reject_cnt + CNT_W'(1);
            if (w_drop && (r_drop_cnt != '1))     r_drop_cnt   <= r_drop_cnt + CNT_W'(1);
        end
    end

    assign reject_cnt = r_reject_cnt;
    assign drop_cnt   = r_drop_cnt;
`else
    assign reject_cnt = '0;
    assign drop_cnt   = '0;
`endif

endmodule
